// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: state codes, opcodes/funcs,
// decoded op classes and PC source selects.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_e;

  localparam logic [5:0] OP_R_FORM = 6'h00;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_JALR   = 6'h09;

  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_JMP = 2'd2;
  localparam logic [1:0] PC_REG = 2'd3;

  typedef enum logic [3:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BEQ,
    CLS_BNE,
    CLS_J,
    CLS_JAL,
    CLS_JR,
    CLS_JALR,
    CLS_ILLEGAL
  } op_cls_e;

  // Classes that write a result register after EXEC.
  function automatic logic cls_writes_reg(input op_cls_e c);
    return (c == CLS_ALU) || (c == CLS_JAL) || (c == CLS_JALR);
  endfunction

endpackage

// File: rtl/mc_ctrl_op_class.sv
// Combinational opcode/func to op-class decode for the multicycle controller.
module op_class
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output op_cls_e    cls
);

  always_comb begin
    cls = CLS_ILLEGAL;
    case (opcode)
      OP_R_FORM: begin
        case (funct)
          FN_JR:   cls = CLS_JR;
          FN_JALR: cls = CLS_JALR;
          default: cls = CLS_ALU;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI,
      OP_ANDI, OP_ORI, OP_XORI: cls = CLS_ALU;
      OP_LW:   cls = CLS_LOAD;
      OP_SW:   cls = CLS_STORE;
      OP_BEQ:  cls = CLS_BEQ;
      OP_BNE:  cls = CLS_BNE;
      OP_J:    cls = CLS_J;
      OP_JAL:  cls = CLS_JAL;
      default: cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle instruction sequencer: fetch/decode/exec/mem/wb with memory
// wait timeout, sticky error flags and a retired-instruction counter.
//
// state  | meaning
// IDLE   | stopped, waiting for Run
// FETCH  | instruction read in flight, waiting for MemAck
// DECODE | op class resolved from Ins
// EXEC   | ALU active, jumps/branches load PC here
// MEM    | load/store in flight, waiting for MemAck
// WB     | one-cycle register write
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Run,
  input  logic [31:0] Ins,
  input  logic        Zero,
  input  logic        MemAck,
  output logic        MemReq,
  output logic        MemWr,
  output logic        IrLoad,
  output logic        PcLoad,
  output logic [1:0]  PcSrc,
  output logic        RegWE,
  output logic        ExEn,
  output logic        Busy,
  output logic        Illegal,
  output logic        Timeout,
  output logic [2:0]  State,
  output logic [31:0] RetireCnt
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  state_e        state, state_nxt;
  op_cls_e       cls;
  logic [WW-1:0] wait_cnt;
  logic          retire, to_hit, wait_last, take_br, is_jump;
  logic          unused_ins_bits;

  op_class u_op_class (
    .opcode (Ins[31:26]),
    .funct  (Ins[5:0]),
    .cls    (cls)
  );

  assign unused_ins_bits = ^Ins[25:6];
  assign wait_last = (wait_cnt == WW'(MEM_TIMEOUT - 1));
  assign take_br   = ((cls == CLS_BEQ) && Zero) || ((cls == CLS_BNE) && !Zero);
  assign is_jump   = (cls == CLS_J) || (cls == CLS_JAL) || (cls == CLS_JR) || (cls == CLS_JALR);

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    to_hit    = 1'b0;
    case (state)
      ST_IDLE:   if (Run) state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (MemAck) state_nxt = ST_DECODE;
        else if (wait_last) begin
          state_nxt = ST_IDLE;
          to_hit    = 1'b1;
        end
      end
      ST_DECODE: begin
        if (cls == CLS_ILLEGAL) retire = 1'b1;
        else                    state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        if (cls_writes_reg(cls))                          state_nxt = ST_WB;
        else if ((cls == CLS_LOAD) || (cls == CLS_STORE)) state_nxt = ST_MEM;
        else                                              retire = 1'b1;
      end
      ST_MEM: begin
        if (MemAck) begin
          if (cls == CLS_LOAD) state_nxt = ST_WB;
          else                 retire = 1'b1;
        end else if (wait_last) begin
          state_nxt = ST_IDLE;
          to_hit    = 1'b1;
        end
      end
      ST_WB:     retire = 1'b1;
      default:   state_nxt = ST_IDLE;
    endcase
    // Instruction boundary: Run decides whether to continue.
    if (retire) state_nxt = Run ? ST_FETCH : ST_IDLE;
  end

  // PC/IR strobes react to MemAck and Zero in the same cycle.
  always_comb begin
    IrLoad = 1'b0;
    PcLoad = 1'b0;
    PcSrc  = PC_SEQ;
    if ((state == ST_FETCH) && MemAck) begin
      IrLoad = 1'b1;
      PcLoad = 1'b1;
    end else if (state == ST_EXEC) begin
      if ((cls == CLS_J) || (cls == CLS_JAL)) PcSrc = PC_JMP;
      else if ((cls == CLS_JR) || (cls == CLS_JALR)) PcSrc = PC_REG;
      else if (take_br) PcSrc = PC_BR;
      PcLoad = is_jump || take_br;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      RetireCnt <= '0;
      Illegal   <= 1'b0;
      Timeout   <= 1'b0;
      MemReq    <= 1'b0;
      MemWr     <= 1'b0;
      ExEn      <= 1'b0;
      RegWE     <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (retire) RetireCnt <= RetireCnt + 32'd1;
      if ((state == ST_DECODE) && (cls == CLS_ILLEGAL)) Illegal <= 1'b1;
      if (to_hit) Timeout <= 1'b1;
      if (state_nxt != state) wait_cnt <= '0;
      else if (((state == ST_FETCH) || (state == ST_MEM)) && !MemAck) wait_cnt <= wait_cnt + WW'(1);
      // Moore outputs registered from the next state.
      MemReq <= (state_nxt == ST_FETCH) || (state_nxt == ST_MEM);
      MemWr  <= (state_nxt == ST_MEM) && (cls == CLS_STORE);
      ExEn   <= (state_nxt == ST_EXEC);
      RegWE  <= (state_nxt == ST_WB);
      Busy   <= (state_nxt != ST_IDLE);
    end
  end

  assign State = state;

endmodule
